// File: rtl/cfi_ss_pkg.sv
// Shared types and constants for the shadow-stack controller.
// Covers the operation encoding, FSM states and exception cause/tval codes.
package cfi_ss_pkg;

  typedef enum logic [1:0] {
    SS_PUSH   = 2'd0,
    SS_POPCHK = 2'd1,
    SS_RDP    = 2'd2
  } ss_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ss_state_t;

  localparam int unsigned CAUSE_ACCESS = 7;
  localparam int unsigned CAUSE_SWCHK  = 18;
  localparam int unsigned TVAL_SSCHK   = 3;
  localparam int unsigned TVAL_BOUNDS  = 4;

endpackage

// File: rtl/cfi_ss_ctrl_if.sv
// Memory-side request/response bus of the shadow-stack controller.
// The controller drives it through the master modport.
interface cfi_ss_ctrl_if #(
  parameter int XLEN = 64
) ();

  logic            mem_req_o;
  logic            mem_gnt_i;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            mem_err_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i,
    input  mem_err_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i,
    output mem_err_i
  );

endinterface

// File: rtl/cfi_ss_bounds.sv
// Shadow-stack region comparator: flags a push below the base
// or a pop-check at/above the limit.
module cfi_ss_bounds
  import cfi_ss_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  ss_op_t          op_i,
  input  logic [XLEN-1:0] ssp_i,
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] limit_i,
  output logic            viol_o
);

  localparam logic [XLEN-1:0] SBV = XLEN'(XLEN / 8);

  logic [XLEN-1:0] push_addr;

  // Compare the would-be access against the region for the given op.
  always_comb begin
    push_addr = ssp_i - SBV;
    viol_o    = 1'b0;
    if (op_i == SS_PUSH)
      viol_o = push_addr < base_i;
    else if (op_i == SS_POPCHK)
      viol_o = ssp_i >= limit_i;
  end

endmodule

// File: rtl/cfi_ss_ctrl.sv
// Shadow-stack push / pop-check / read-pointer controller.
// Define CFI_SS_BOUNDS_EN to add base/limit region checking.
module cfi_ss_ctrl
  import cfi_ss_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             sse_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  ss_op_t           op_i,
  input  logic [XLEN-1:0]  data_i,
  cfi_ss_ctrl_if.master    mem,
  input  logic             ssp_we_i,
  input  logic [XLEN-1:0]  ssp_wdata_i,
  output logic [XLEN-1:0]  ssp_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_cause_o,
  output logic [XLEN-1:0]  ex_tval_o
`ifdef CFI_SS_BOUNDS_EN
  ,
  input  logic [XLEN-1:0]  ss_base_i,
  input  logic [XLEN-1:0]  ss_limit_i
`endif
);

  localparam int SB = XLEN / 8;
  localparam int AW = $clog2(SB);
  localparam logic [XLEN-1:0] SBV = XLEN'(SB);

  ss_state_t       state_q, state_d;
  logic [XLEN-1:0] ssp_q, ssp_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            we_q, we_d;
  logic            exp_q, exp_d;
  logic [XLEN-1:0] exc_q, exc_d;
  logic [XLEN-1:0] ext_q, ext_d;

  logic [XLEN-1:0] ssp_eff;
  logic [XLEN-1:0] push_addr;
  logic            accept;
  logic            misal;
  logic            is_mem_op;
  logic            bnd_viol;

  assign ssp_eff   = (state_q == IDLE && ssp_we_i) ? ssp_wdata_i : ssp_q;
  assign push_addr = ssp_eff - SBV;
  assign misal     = |ssp_eff[AW-1:0];
  assign is_mem_op = (op_i == SS_PUSH) || (op_i == SS_POPCHK);
  assign ready_o   = (state_q == IDLE) && !exp_q;
  assign accept    = valid_i && ready_o;

`ifdef CFI_SS_BOUNDS_EN
  cfi_ss_bounds #(
    .XLEN    (XLEN)
  ) u_bounds (
    .op_i    (op_i),
    .ssp_i   (ssp_eff),
    .base_i  (ss_base_i),
    .limit_i (ss_limit_i),
    .viol_o  (bnd_viol)
  );
`else
  assign bnd_viol = 1'b0;
`endif

  assign ssp_o           = ssp_q;
  assign mem.mem_req_o   = state_q == REQ;
  assign mem.mem_we_o    = (state_q == REQ) && we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = we_q ? data_q : '0;

  // Next-state, pointer update and completion/exception outputs.
  always_comb begin
    state_d    = state_q;
    ssp_d      = ssp_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    exp_d      = 1'b0;
    exc_d      = '0;
    ext_d      = '0;
    done_o     = 1'b0;
    result_o   = '0;
    ex_valid_o = exp_q;
    ex_cause_o = exp_q ? exc_q : '0;
    ex_tval_o  = exp_q ? ext_q : '0;
    unique case (state_q)
      IDLE: begin
        ssp_d = ssp_eff;
        if (accept) begin
          if (op_i == SS_RDP) begin
            done_o   = 1'b1;
            result_o = sse_i ? ssp_eff : '0;
          end else if (!sse_i || !is_mem_op) begin
            done_o = 1'b1;
          end else if (misal) begin
            exp_d = 1'b1;
            exc_d = XLEN'(CAUSE_ACCESS);
            ext_d = (op_i == SS_PUSH) ? push_addr : ssp_eff;
          end else if (bnd_viol) begin
            exp_d = 1'b1;
            exc_d = XLEN'(CAUSE_SWCHK);
            ext_d = XLEN'(TVAL_BOUNDS);
          end else begin
            state_d = REQ;
            we_d    = op_i == SS_PUSH;
            addr_d  = (op_i == SS_PUSH) ? push_addr : ssp_eff;
            data_d  = data_i;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt_i)
          state_d = flush_i ? DRAIN : WAIT;
        else if (flush_i)
          state_d = IDLE;
      end
      WAIT: begin
        if (flush_i) begin
          state_d = mem.mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem.mem_rvalid_i) begin
          state_d = IDLE;
          if (mem.mem_err_i) begin
            ex_valid_o = 1'b1;
            ex_cause_o = XLEN'(CAUSE_ACCESS);
            ex_tval_o  = addr_q;
          end else if (we_q) begin
            done_o = 1'b1;
            ssp_d  = addr_q;
          end else if (mem.mem_rdata_i != data_q) begin
            ex_valid_o = 1'b1;
            ex_cause_o = XLEN'(CAUSE_SWCHK);
            ex_tval_o  = XLEN'(TVAL_SSCHK);
          end else begin
            done_o = 1'b1;
            ssp_d  = ssp_q + SBV;
          end
        end
      end
      DRAIN: begin
        if (mem.mem_rvalid_i)
          state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ssp_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      exp_q   <= 1'b0;
      exc_q   <= '0;
      ext_q   <= '0;
    end else begin
      state_q <= state_d;
      ssp_q   <= ssp_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      exp_q   <= exp_d;
      exc_q   <= exc_d;
      ext_q   <= ext_d;
    end
  end

endmodule

// File: tb/tb_cfi_ss_ctrl.sv
// Directed bench for cfi_ss_ctrl (XLEN=64) with a completion scoreboard.
// Builds with or without CFI_SS_BOUNDS_EN; bounds kept wide open.
module tb_cfi_ss_ctrl;
  import cfi_ss_pkg::*;

  localparam int XLEN = 64;

  typedef struct {
    logic        ex;
    logic [63:0] cause;
    logic        tv;
    logic [63:0] tval;
    logic        rd;
    logic [63:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        sse = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  ss_op_t      op = SS_RDP;
  logic [63:0] data = '0;
  logic        ssp_we = 1'b0;
  logic [63:0] ssp_wdata = '0;
  logic [63:0] ssp;
  logic        done;
  logic [63:0] result;
  logic        ex_valid;
  logic [63:0] ex_cause;
  logic [63:0] ex_tval;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t e;

  cfi_ss_ctrl_if #(.XLEN(XLEN)) mem ();

  cfi_ss_ctrl #(.XLEN(XLEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .sse_i       (sse),
    .valid_i     (valid),
    .ready_o     (ready),
    .op_i        (op),
    .data_i      (data),
    .mem         (mem),
    .ssp_we_i    (ssp_we),
    .ssp_wdata_i (ssp_wdata),
    .ssp_o       (ssp),
    .done_o      (done),
    .result_o    (result),
    .ex_valid_o  (ex_valid),
    .ex_cause_o  (ex_cause),
    .ex_tval_o   (ex_tval)
`ifdef CFI_SS_BOUNDS_EN
    ,
    .ss_base_i   (64'h0),
    .ss_limit_i  ({64{1'b1}})
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ssp(logic [63:0] v);
    ssp_we = 1'b1;
    ssp_wdata = v;
    tick();
    ssp_we = 1'b0;
    chk("csr_ssp", ssp, v);
  endtask

  task automatic issue(ss_op_t o, logic [63:0] d);
    valid = 1'b1;
    op = o;
    data = d;
    tick();
    valid = 1'b0;
  endtask

  task automatic grant_resp(logic [63:0] rd, logic err);
    mem.mem_gnt_i = 1'b1;
    tick();
    mem.mem_gnt_i = 1'b0;
    mem.mem_rvalid_i = 1'b1;
    mem.mem_rdata_i = rd;
    mem.mem_err_i = err;
    tick();
    mem.mem_rvalid_i = 1'b0;
    mem.mem_err_i = 1'b0;
  endtask

  function automatic exp_t mk(logic ex, logic [63:0] c, logic tv,
                              logic [63:0] t, logic rd,
                              logic [63:0] r);
    exp_t x;
    x.ex = ex; x.cause = c; x.tv = tv;
    x.tval = t; x.rd = rd; x.res = r;
    return x;
  endfunction

  // Scoreboard: every done/exception pulse must match the oldest entry.
  always @(negedge clk) begin
    if (done || ex_valid) begin
      chk("exclusive", {63'b0, done & ex_valid}, 64'd0);
      chk("sb_avail", {63'b0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("kind_ex", {63'b0, ex_valid}, {63'b0, e.ex});
        if (e.ex) chk("cause", ex_cause, e.cause);
        if (e.ex && e.tv) chk("tval", ex_tval, e.tval);
        if (e.rd) chk("result", result, e.res);
      end
    end
  end

  initial begin
    mem.mem_gnt_i = 1'b0;
    mem.mem_rvalid_i = 1'b0;
    mem.mem_rdata_i = '0;
    mem.mem_err_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'b0, ready}, 64'd1);
    chk("rst_ssp", ssp, 64'd0);
    chk("rst_req", {63'b0, mem.mem_req_o}, 64'd0);
    chk("rst_ex", {63'b0, ex_valid}, 64'd0);
    tick();
    rst = 1'b0;

    // push to an aligned stack
    set_ssp(64'h1000);
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    issue(SS_PUSH, 64'hABCD);
    @(negedge clk);
    chk("push_req", {63'b0, mem.mem_req_o}, 64'd1);
    chk("push_addr", mem.mem_addr_o, 64'hFF8);
    chk("push_we", {63'b0, mem.mem_we_o}, 64'd1);
    chk("push_wdata", mem.mem_wdata_o, 64'hABCD);
    chk("push_busy", {63'b0, ready}, 64'd0);
    grant_resp(64'h0, 1'b0);
    chk("push_ssp", ssp, 64'hFF8);
    chk("push_idle", {63'b0, ready}, 64'd1);

    // pop-check with matching link
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    issue(SS_POPCHK, 64'hABCD);
    @(negedge clk);
    chk("pop_addr", mem.mem_addr_o, 64'hFF8);
    chk("pop_we", {63'b0, mem.mem_we_o}, 64'd0);
    grant_resp(64'hABCD, 1'b0);
    chk("pop_ssp", ssp, 64'h1000);

    // pop-check mismatch
    set_ssp(64'hFF8);
    sb.push_back(mk(1, 18, 1, 3, 0, 0));
    issue(SS_POPCHK, 64'hABCD);
    grant_resp(64'h1234, 1'b0);
    chk("mis_ssp", ssp, 64'hFF8);

    // grant stall keeps the request stable
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    issue(SS_PUSH, 64'h5555);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", {63'b0, mem.mem_req_o}, 64'd1);
      chk("stall_addr", mem.mem_addr_o, 64'hFF0);
      chk("stall_wdata", mem.mem_wdata_o, 64'h5555);
      chk("stall_ready", {63'b0, ready}, 64'd0);
      tick();
    end
    grant_resp(64'h0, 1'b0);
    chk("stall_ssp", ssp, 64'hFF0);

    // flush in WAIT, then an erroring response is drained
    issue(SS_POPCHK, 64'h1);
    mem.mem_gnt_i = 1'b1;
    tick();
    mem.mem_gnt_i = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem.mem_rvalid_i = 1'b1;
    mem.mem_err_i = 1'b1;
    tick();
    mem.mem_rvalid_i = 1'b0;
    mem.mem_err_i = 1'b0;
    @(negedge clk);
    chk("drain_ssp", ssp, 64'hFF0);
    chk("drain_ready", {63'b0, ready}, 64'd1);
    tick();

    // flush in REQ before grant
    issue(SS_PUSH, 64'h9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_req", {63'b0, mem.mem_req_o}, 64'd0);
    chk("fl_ready", {63'b0, ready}, 64'd1);
    chk("fl_ssp", ssp, 64'hFF0);
    tick();

    // store access error
    sb.push_back(mk(1, 7, 1, 64'hFE8, 0, 0));
    issue(SS_PUSH, 64'h2);
    grant_resp(64'h0, 1'b1);
    chk("err_ssp", ssp, 64'hFF0);

    // misaligned pointer: exception, no memory traffic
    set_ssp(64'h1004);
    sb.push_back(mk(1, 7, 0, 0, 0, 0));
    issue(SS_PUSH, 64'h3);
    @(negedge clk);
    chk("mal_noreq", {63'b0, mem.mem_req_o}, 64'd0);
    tick();
    @(negedge clk);
    chk("mal_noreq2", {63'b0, mem.mem_req_o}, 64'd0);
    chk("mal_ssp", ssp, 64'h1004);
    tick();

    // read pointer with and without shadow stack enabled
    sse = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 1, 64'h0));
    valid = 1'b1;
    op = SS_RDP;
    @(negedge clk);
    chk("rdp0_done", {63'b0, done}, 64'd1);
    tick();
    sse = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 1, 64'h1004));
    tick();
    valid = 1'b0;

    // disabled push is a same-cycle no-op
    sse = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    issue(SS_PUSH, 64'h4);
    @(negedge clk);
    chk("nop_req", {63'b0, mem.mem_req_o}, 64'd0);
    chk("nop_ssp", ssp, 64'h1004);
    sse = 1'b1;
    tick();

    // CSR write coincident with acceptance wins
    ssp_we = 1'b1;
    ssp_wdata = 64'h2000;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    issue(SS_PUSH, 64'h77);
    ssp_we = 1'b0;
    @(negedge clk);
    chk("csrw_addr", mem.mem_addr_o, 64'h1FF8);
    grant_resp(64'h0, 1'b0);
    chk("csrw_ssp", ssp, 64'h1FF8);

    // reset while waiting for the response
    issue(SS_PUSH, 64'h88);
    mem.mem_gnt_i = 1'b1;
    tick();
    mem.mem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_ssp", ssp, 64'h0);
    chk("rstw_ready", {63'b0, ready}, 64'd1);
    mem.mem_rvalid_i = 1'b1;
    tick();
    mem.mem_rvalid_i = 1'b0;
    tick();
    chk("late_ssp", ssp, 64'h0);
    chk("late_ready", {63'b0, ready}, 64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
